fixed_pos_packer: RTL and testbench
===================================

FIXED_POS_PACKER -- requirements
Module: fixed_pos_packer

Interface
REQ-001 SHALL have parameter CELL_ID_WIDTH, default 3, giving the width of the cell-id field of each packed word.
REQ-002 SHALL have parameter FRAC_WIDTH, default 29 (32-CELL_ID_WIDTH), giving the width of the fraction per axis.
REQ-003 SHALL have parameter ADDR_WIDTH, default 7, giving the width of the cell position memory address.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins packing one cell; ignored unless in IDLE.
REQ-007 cell_off_x/y/z  input  2 each  neighbour-cell offset per axis, 0..2; sampled on accepted start.
REQ-008 num_particles  input  ADDR_WIDTH+1  particle count of the cell; sampled on accepted start.
REQ-009 mem_rd_en  output  1  read strobe to the cell position memory.
REQ-010 mem_addr  output  ADDR_WIDTH  read address.
REQ-011 mem_rdata  input  3*FRAC_WIDTH  {z,y,x} fractions; valid exactly 1 cycle after mem_rd_en.
REQ-012 out_valid / out_ready  output / input  1 / 1  standard valid-ready handshake to fixed2float stage.
REQ-013 out_x/y/z  output  32 each  packed fixed-point position.
REQ-014 out_last  output  1  marks final particle of the cell.
REQ-015 busy, done  output  1, 1  busy high outside IDLE; done one-cycle pulse after last beat accepted.
REQ-016 err  output  1  one-cycle pulse on rejected start (only with the macro of REQ-035).

Function
REQ-017 Packing rule per axis: out_a = {(cell_off_a + 1) zero-extended to CELL_ID_WIDTH, fraction_a}; offsets 0,1,2 give cell ids 3'b001, 3'b010, 3'b011.
REQ-018 Addition SHALL be unsigned, performed in CELL_ID_WIDTH bits, no saturation.
REQ-019 FSM states: IDLE, FETCH, DRAIN.
REQ-020 IDLE -> FETCH on start with num_particles > 0; IDLE -> IDLE with a one-cycle done pulse on start with num_particles == 0.
REQ-021 FETCH: mem_addr counts from 0 upward by 1 per issued read; FETCH -> DRAIN when read num_particles-1 is issued.
REQ-022 DRAIN -> IDLE when the beat with out_last is accepted (out_valid & out_ready); done pulses the following cycle.
REQ-023 Output SHALL be a 2-entry FIFO; a read SHALL be issued only when (FIFO occupancy + reads in flight) < 2, so no data is ever dropped under backpressure.
REQ-024 Sustained throughput SHALL be 1 beat/cycle when out_ready is held high; first out_valid 2 cycles after accepted start.
REQ-025 Outputs SHALL hold stable while out_valid & !out_ready.
REQ-026 out_last SHALL be high only on the beat of particle index num_particles-1.
REQ-027 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-028 start during FETCH or DRAIN SHALL be ignored with no effect on the current cell.
REQ-029 Offsets and count SHALL be registered at start; input changes mid-cell have no effect.
REQ-030 num_particles = 2^ADDR_WIDTH SHALL read every address once; mem_addr does not wrap within a cell.

Reset
REQ-031 On rst_n low, immediately: state IDLE, FIFO empty, address counter 0.
REQ-032 Reset values: out_valid 0, out_last 0, out_x/y/z 0, mem_rd_en 0, mem_addr 0, busy 0, done 0, err 0.
REQ-033 Reset mid-cell SHALL abandon the cell; in-flight read data returning after reset release SHALL be discarded.
REQ-034 First start SHALL be accepted on the first clock edge after rst_n deasserts.

Configuration
REQ-035 Macro POS_PACK_OFFSET_CHECK_EN: when defined, start with any cell_off_a == 2'd3 SHALL be rejected (stay IDLE, err pulse 1 cycle, no reads issued).
REQ-036 Without POS_PACK_OFFSET_CHECK_EN, offset 3 SHALL be packed unchecked (cell id 3'b100) and err SHALL be tied 0.

Verification
REQ-037 start, offsets (0,1,2), count 3, out_ready=1, mem x-fractions 0x0000001/2/3 -> three beats cycles 2..4 after start, out_x cell field 3'b001, out_z 3'b011, out_last on third beat, done next cycle.
REQ-038 count 4, out_ready low 5 cycles after first valid -> at most 2 reads ahead of accepted beats, no beat lost or duplicated, beat order addr 0..3.
REQ-039 start with count 0 -> no mem_rd_en, done pulse next cycle, busy stays 0.
REQ-040 rst_n asserted mid-FETCH of 8-particle cell -> all outputs zero at once; next start with count 2 yields exactly 2 beats from addr 0.
REQ-041 With POS_PACK_OFFSET_CHECK_EN, start with cell_off_y=3 -> err pulse, no reads, busy 0; without macro, out_y cell field 3'b100.
REQ-042 start pulsed again during DRAIN -> ignored; beat count equals first num_particles.

Source files
------------

// File: rtl/fixed_pos_packer_if.sv
// rtl/fixed_pos_packer_if.sv - packed position output stream towards the fixed2float stage
interface fixed_pos_packer_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [31:0] out_z;
    logic        out_last;

    modport master (
        output out_valid,
        output out_x,
        output out_y,
        output out_z,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_x,
        input  out_y,
        input  out_z,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fixed_pos_packer.sv
// rtl/fixed_pos_packer.sv - fetch cell positions and pack cell id + fraction per axis (optional POS_PACK_OFFSET_CHECK_EN)
module fixed_pos_packer #(
    parameter int CELL_ID_WIDTH = 3,
    parameter int FRAC_WIDTH    = 29,
    parameter int ADDR_WIDTH    = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                cell_off_x,
    input  logic [1:0]                cell_off_y,
    input  logic [1:0]                cell_off_z,
    input  logic [ADDR_WIDTH:0]       num_particles,
    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [3*FRAC_WIDTH-1:0]   mem_rdata,
    fixed_pos_packer_if.master        pos,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int ENTRY_W = 1 + 3 * 32;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state;
    logic [1:0]            off_x_q;
    logic [1:0]            off_y_q;
    logic [1:0]            off_z_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  rd_valid;
    logic                  rd_last;
    logic [ENTRY_W-1:0]    fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic                  push;
    logic                  pop;
    logic                  last_read;
    logic                  bad_offset;

    // Cell id is the neighbour offset plus one, wrapping in CELL_ID_WIDTH bits.
    function automatic logic [31:0] pack(input logic [1:0] off, input logic [FRAC_WIDTH-1:0] frac);
        logic [CELL_ID_WIDTH-1:0] cid;
        cid = CELL_ID_WIDTH'(off) + CELL_ID_WIDTH'(1);
        return 32'({cid, frac});
    endfunction

`ifdef POS_PACK_OFFSET_CHECK_EN
    assign bad_offset = (cell_off_x == 2'd3) || (cell_off_y == 2'd3) || (cell_off_z == 2'd3);
`else
    assign bad_offset = 1'b0;
`endif

    assign pop           = pos.out_valid & pos.out_ready;
    assign push          = rd_valid;
    assign pos.out_valid = (occ != 2'd0);
    assign {pos.out_last, pos.out_z, pos.out_y, pos.out_x} = fifo_mem[rd_ptr];
    assign busy          = (state != IDLE);
    assign last_read     = ({1'b0, mem_addr} == (count_q - {{ADDR_WIDTH{1'b0}}, 1'b1}));

    // A read may go out only if its data is guaranteed a FIFO slot; a same-cycle pop frees one.
    assign mem_rd_en = (state == FETCH) &&
                       (({1'b0, occ} + {2'b00, rd_valid} - {2'b00, pop}) < 3'd2);

    // Cell sequencing: capture the request, issue reads, wait for the last beat to leave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_addr <= '0;
            off_x_q  <= '0;
            off_y_q  <= '0;
            off_z_q  <= '0;
            count_q  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= mem_rd_en;
            rd_last  <= mem_rd_en && last_read;
            if (mem_rd_en) begin
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (start && !bad_offset) begin
                        off_x_q  <= cell_off_x;
                        off_y_q  <= cell_off_y;
                        off_z_q  <= cell_off_z;
                        count_q  <= num_particles;
                        mem_addr <= '0;
                        if (num_particles == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (mem_rd_en && last_read) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && pos.out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry output FIFO; returning read data is packed as it is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {rd_last,
                                     pack(off_z_q, mem_rdata[3*FRAC_WIDTH-1:2*FRAC_WIDTH]),
                                     pack(off_y_q, mem_rdata[2*FRAC_WIDTH-1:FRAC_WIDTH]),
                                     pack(off_x_q, mem_rdata[FRAC_WIDTH-1:0])};
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef POS_PACK_OFFSET_CHECK_EN
    // Flag a start rejected because one of its offsets names a nonexistent neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= (state == IDLE) && start && bad_offset;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fixed_pos_packer.sv
// tb/tb_fixed_pos_packer.sv - directed self-checking bench for fixed_pos_packer
module tb_fixed_pos_packer;
    localparam int AW = 7;
    localparam int FW = 29;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      offx = 2'd0;
    logic [1:0]      offy = 2'd0;
    logic [1:0]      offz = 2'd0;
    logic [AW:0]     num = '0;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_addr;
    logic [3*FW-1:0] mem_rdata = '0;
    logic            busy;
    logic            done;
    logic            err;
    int              cyc = 0;

    fixed_pos_packer_if pos ();

    fixed_pos_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cell_off_x    (offx),
        .cell_off_y    (offy),
        .cell_off_z    (offz),
        .num_particles (num),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .pos           (pos),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [FW-1:0] frac_x(input int a); return FW'(a + 1);        endfunction
    function automatic logic [FW-1:0] frac_y(input int a); return FW'(a + 'h100);    endfunction
    function automatic logic [FW-1:0] frac_z(input int a); return FW'(a + 'h10000);  endfunction

    // Position memory: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= {frac_z(int'(mem_addr)), frac_y(int'(mem_addr)), frac_x(int'(mem_addr))};
    end

    logic [31:0] bx[$];
    logic [31:0] by[$];
    logic [31:0] bz[$];
    bit          bl[$];
    int          bcyc[$];
    int          raddr[$];
    int          done_cyc[$];
    int          err_cnt, n_reads, n_beats, max_ahead;
    bit          busy_seen;
    int          n_checks = 0;
    int          n_fail = 0;

    // Record reads, accepted beats and status pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                raddr.push_back(int'(mem_addr));
                n_reads++;
            end
            if (pos.out_valid && pos.out_ready) begin
                bx.push_back(pos.out_x);
                by.push_back(pos.out_y);
                bz.push_back(pos.out_z);
                bl.push_back(pos.out_last);
                bcyc.push_back(cyc);
                n_beats++;
            end
            if (n_reads - n_beats > max_ahead) max_ahead = n_reads - n_beats;
            if (done) done_cyc.push_back(cyc);
            if (err) err_cnt++;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        bx.delete(); by.delete(); bz.delete(); bl.delete(); bcyc.delete();
        raddr.delete(); done_cyc.delete();
        err_cnt = 0; n_reads = 0; n_beats = 0; max_ahead = 0; busy_seen = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive a start pulse for one edge, then scramble the sampled inputs.
    task automatic pulse_start(input logic [1:0] x, input logic [1:0] y, input logic [1:0] z,
                               input logic [AW:0] n, output int s);
        offx = x; offy = y; offz = z; num = n; start = 1'b1;
        next_cycle();
        s = cyc;
        start = 1'b0;
        offx = 2'd2; offy = 2'd0; offz = 2'd1; num = 8'd9;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && done_cyc.size() == 0; i++) @(negedge clk);
        check_eq(tag, 64'(done_cyc.size() > 0), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_valid"}, 64'(pos.out_valid), 64'd0);
        check_eq({tag, "_last"},  64'(pos.out_last),  64'd0);
        check_eq({tag, "_xyz"},   {pos.out_x, pos.out_y | pos.out_z}, 64'd0);
        check_eq({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
        check_eq({tag, "_addr"},  64'(mem_addr),  64'd0);
        check_eq({tag, "_stat"},  64'({busy, done, err}), 64'd0);
    endtask

    logic [31:0] exp_x3 [3] = '{32'h2000_0001, 32'h2000_0002, 32'h2000_0003};
    logic [31:0] exp_y3 [3] = '{32'h4000_0100, 32'h4000_0101, 32'h4000_0102};
    logic [31:0] exp_z3 [3] = '{32'h6001_0000, 32'h6001_0001, 32'h6001_0002};

    initial begin
        int s;
        pos.out_ready = 1'b0;
        clear_mon();
        #1 rst_n = 1'b0;
        #20;
        check_zero_outputs("reset");

        // Basic cell: accepted on the very first edge after reset release.
        pos.out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse_start(2'd0, 2'd1, 2'd2, 8'd3, s);
        wait_done("basic_done_seen");
        check_eq("basic_beats", 64'(bx.size()), 64'd3);
        for (int i = 0; i < 3 && i < bx.size(); i++) begin
            check_eq($sformatf("basic_cyc%0d", i), 64'(bcyc[i] - s), 64'(i + 2));
            check_eq($sformatf("basic_x%0d", i), 64'(bx[i]), 64'(exp_x3[i]));
            check_eq($sformatf("basic_y%0d", i), 64'(by[i]), 64'(exp_y3[i]));
            check_eq($sformatf("basic_z%0d", i), 64'(bz[i]), 64'(exp_z3[i]));
            check_eq($sformatf("basic_last%0d", i), 64'(bl[i]), 64'(i == 2));
            check_eq($sformatf("basic_addr%0d", i), 64'(raddr[i]), 64'(i));
        end
        if (done_cyc.size() > 0) check_eq("basic_done_cyc", 64'(done_cyc[0] - s), 64'd5);
        check_eq("basic_done_once", 64'(done_cyc.size()), 64'd1);

        // Backpressure: five stalled cycles after the first valid beat.
        clear_mon();
        pos.out_ready = 1'b0;
        next_cycle();
        pulse_start(2'd1, 2'd1, 2'd1, 8'd4, s);
        for (int i = 0; i < 50 && !pos.out_valid; i++) @(negedge clk);
        check_eq("bp_first_valid", 64'(pos.out_valid), 64'd1);
        repeat (5) @(negedge clk);
        check_eq("bp_hold_valid", 64'(pos.out_valid), 64'd1);
        check_eq("bp_hold_x", 64'(pos.out_x), 64'h4000_0001);
        check_eq("bp_hold_last", 64'(pos.out_last), 64'd0);
        check_eq("bp_reads_stalled", 64'(n_reads), 64'd2);
        next_cycle();
        pos.out_ready = 1'b1;
        wait_done("bp_done_seen");
        check_eq("bp_beats", 64'(bx.size()), 64'd4);
        check_eq("bp_reads", 64'(n_reads), 64'd4);
        check_eq("bp_ahead", 64'(max_ahead), 64'd2);
        for (int i = 0; i < 4 && i < bx.size(); i++) begin
            check_eq($sformatf("bp_x%0d", i), 64'(bx[i]), 64'h4000_0001 + 64'(i));
            check_eq($sformatf("bp_last%0d", i), 64'(bl[i]), 64'(i == 3));
        end

        // Empty cell: immediate done, no reads, never busy.
        clear_mon();
        next_cycle();
        pulse_start(2'd0, 2'd0, 2'd0, 8'd0, s);
        repeat (5) @(negedge clk);
        check_eq("empty_done_cnt", 64'(done_cyc.size()), 64'd1);
        if (done_cyc.size() > 0) check_eq("empty_done_cyc", 64'(done_cyc[0] - s), 64'd0);
        check_eq("empty_reads", 64'(n_reads), 64'd0);
        check_eq("empty_busy", 64'(busy_seen), 64'd0);

        // Reset in the middle of an 8-particle fetch, then a fresh 2-particle cell.
        clear_mon();
        next_cycle();
        pulse_start(2'd0, 2'd0, 2'd0, 8'd8, s);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        next_cycle();
        clear_mon();
        rst_n = 1'b1;
        pulse_start(2'd2, 2'd0, 2'd1, 8'd2, s);
        wait_done("midrst_done_seen");
        repeat (5) @(negedge clk);
        check_eq("midrst_beats", 64'(bx.size()), 64'd2);
        for (int i = 0; i < 2 && i < bx.size(); i++) begin
            check_eq($sformatf("midrst_addr%0d", i), 64'(raddr[i]), 64'(i));
            check_eq($sformatf("midrst_x%0d", i), 64'(bx[i]), 64'h6000_0001 + 64'(i));
            check_eq($sformatf("midrst_z%0d", i), 64'(bz[i]), 64'h4001_0000 + 64'(i));
            check_eq($sformatf("midrst_last%0d", i), 64'(bl[i]), 64'(i == 1));
        end

        // Offset 3 on the y axis.
        clear_mon();
        next_cycle();
        pulse_start(2'd0, 2'd3, 2'd0, 8'd1, s);
`ifdef POS_PACK_OFFSET_CHECK_EN
        repeat (6) @(negedge clk);
        check_eq("offchk_err", 64'(err_cnt), 64'd1);
        check_eq("offchk_reads", 64'(n_reads), 64'd0);
        check_eq("offchk_busy", 64'(busy_seen), 64'd0);
        check_eq("offchk_done", 64'(done_cyc.size()), 64'd0);
`else
        wait_done("off3_done_seen");
        check_eq("off3_beats", 64'(bx.size()), 64'd1);
        if (by.size() > 0) check_eq("off3_y", 64'(by[0]), 64'h8000_0100);
        check_eq("off3_err", 64'(err_cnt), 64'd0);
`endif

        // Second start during DRAIN must not disturb the running cell.
        clear_mon();
        pos.out_ready = 1'b0;
        next_cycle();
        pulse_start(2'd0, 2'd1, 2'd2, 8'd2, s);
        repeat (4) @(negedge clk);
        check_eq("drain_busy", 64'(busy), 64'd1);
        next_cycle();
        begin
            int s2;
            pulse_start(2'd2, 2'd2, 2'd2, 8'd5, s2);
        end
        pos.out_ready = 1'b1;
        wait_done("drain_done_seen");
        repeat (10) @(negedge clk);
        check_eq("drain_beats", 64'(bx.size()), 64'd2);
        check_eq("drain_reads", 64'(n_reads), 64'd2);
        check_eq("drain_done_cnt", 64'(done_cyc.size()), 64'd1);
        check_eq("drain_idle", 64'(busy), 64'd0);
        for (int i = 0; i < 2 && i < bx.size(); i++) begin
            check_eq($sformatf("drain_x%0d", i), 64'(bx[i]), 64'(exp_x3[i]));
            check_eq($sformatf("drain_z%0d", i), 64'(bz[i]), 64'(exp_z3[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
